// File: rtl/minirisc_pkg.sv
// Shared definitions for the minirisc front end: fetch FSM states,
// instruction width and the default boot address.
package minirisc_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Word-address increment; wraps 32'hFFFF_FFFF to 0 naturally.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer between the instruction memory return path and the
// fetch output register. When the consumer stalls while a word is arriving,
// the word is parked here; the parked word is always presented first.
module fetch_skid_buffer
    import minirisc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    input  logic [31:0]        in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_data,
    output logic [31:0]        out_pc
);

    logic               full_reg, full_next;
    logic [INSTR_W-1:0] data_reg, data_next;
    logic [31:0]        pc_reg,   pc_next;

    // Park an arriving word on a stall, release it when the consumer takes it.
    always_comb begin
        full_next = full_reg;
        data_next = data_reg;
        pc_next   = pc_reg;
        if (flush) begin
            full_next = 1'b0;
        end else if (full_reg) begin
            if (out_ready) begin
                full_next = 1'b0;
            end
        end else if (in_valid && !out_ready) begin
            full_next = 1'b1;
            data_next = in_data;
            pc_next   = in_pc;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
            pc_reg   <= '0;
        end else begin
            full_reg <= full_next;
            data_reg <= data_next;
            pc_reg   <= pc_next;
        end
    end

    assign in_ready  = !full_reg;
    assign out_valid = full_reg || in_valid;
    assign out_data  = full_reg ? data_reg : in_data;
    assign out_pc    = full_reg ? pc_reg   : in_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word reads to a synchronous instruction
// memory, tracks the pc of the in-flight read, and hands instructions to
// decode through a valid/ready output register backed by a skid buffer.
// Supports branch redirects (with flush) and a terminal halt.
module instruction_fetch
    import minirisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 10
)(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        instr_pc,
    output logic               halted
);

    fetch_state_t       state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic               rvalid_reg, rvalid_next;     // read issued last cycle, data arrives now
    logic [31:0]        rpc_reg, rpc_next;           // pc of that read
    logic               halt_pend_reg, halt_pend_next;
    logic               out_valid_reg, out_valid_next;
    logic [INSTR_W-1:0] out_data_reg, out_data_next;
    logic [31:0]        out_pc_reg, out_pc_next;

    logic               issue;
    logic               redirect_take;
    logic               halt_eff;
    logic               out_accept;
    logic               skid_in_ready;
    logic               skid_out_valid;
    logic [INSTR_W-1:0] skid_out_data;
    logic [31:0]        skid_out_pc;
    logic               skid_free;

    // Redirects only act in RUN; in HALT (and the short BOOT/FLUSH windows) they are dropped.
    assign redirect_take = redirect_valid && (state_reg == RUN);
    assign halt_eff      = halt_req || halt_pend_reg;
    assign out_accept    = !out_valid_reg || instr_ready;

    // A new read may be issued only if the skid entry is guaranteed empty when
    // its data comes back: empty now and not capturing, or full and draining.
    assign skid_free = skid_in_ready ? (!rvalid_reg || out_accept) : out_accept;

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_take),
        .in_valid  (rvalid_reg),
        .in_ready  (skid_in_ready),
        .in_data   (imem_rdata),
        .in_pc     (rpc_reg),
        .out_valid (skid_out_valid),
        .out_ready (out_accept),
        .out_data  (skid_out_data),
        .out_pc    (skid_out_pc)
    );

    // Fetch FSM: next state, read issue and pending-halt tracking.
    always_comb begin
        state_next     = state_reg;
        issue          = 1'b0;
        halt_pend_next = halt_pend_reg;
        case (state_reg)
            BOOT: begin
                state_next = RUN;
                if (halt_req) begin
                    halt_pend_next = 1'b1;
                end
            end
            RUN: begin
                if (redirect_take) begin
                    // Redirect wins over a simultaneous halt; halt must be re-asserted.
                    state_next     = FLUSH;
                    halt_pend_next = 1'b0;
                end else begin
                    if (halt_req) begin
                        halt_pend_next = 1'b1;
                    end
                    if (halt_eff) begin
                        // Stop issuing; enter HALT once the last read has returned.
                        if (!rvalid_reg) begin
                            state_next = HALT;
                        end
                    end else begin
                        issue = skid_free;
                    end
                end
            end
            FLUSH: begin
                // Skid and output register were just cleared, so the target read is safe.
                state_next = RUN;
                issue      = 1'b1;
                if (halt_req) begin
                    halt_pend_next = 1'b1;
                end
            end
            HALT: begin
                halt_pend_next = 1'b0;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Pc and in-flight read tracking.
    always_comb begin
        rvalid_next = issue;
        rpc_next    = issue ? pc_reg : rpc_reg;
        if (redirect_take) begin
            pc_next = redirect_pc;
        end else if (issue) begin
            pc_next = pc_inc(pc_reg);
        end else begin
            pc_next = pc_reg;
        end
    end

    // Output register: load from the skid path whenever decode can take a word.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_pc_next    = out_pc_reg;
        if (redirect_take) begin
            out_valid_next = 1'b0;
        end else if (out_accept) begin
            out_valid_next = skid_out_valid;
            if (skid_out_valid) begin
                out_data_next = skid_out_data;
                out_pc_next   = skid_out_pc;
            end
        end
    end

    // State registers; reset abandons any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            rvalid_reg    <= 1'b0;
            rpc_reg       <= '0;
            halt_pend_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            rvalid_reg    <= rvalid_next;
            rpc_reg       <= rpc_next;
            halt_pend_reg <= halt_pend_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_pc_reg    <= out_pc_next;
        end
    end

    assign imem_en     = issue;
    assign imem_addr   = pc_reg[IMEM_AW-1:0];
    assign instr_valid = out_valid_reg;
    assign instr_out   = out_data_reg;
    assign instr_pc    = out_pc_reg;
    assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall, redirect,
// redirect+halt, halt drain and a wrap-around boot address.
module tb_instruction_fetch;
    import minirisc_pkg::*;

    localparam logic [31:0] WA = 32'hA000_000A;
    localparam logic [31:0] WB = 32'hB000_000B;
    localparam logic [31:0] WC = 32'hC000_000C;
    localparam logic [31:0] WD = 32'hD000_000D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        rst_n;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        halted;

    // Second instance booting at 32'hFFFF_FFFF
    logic        b_rst_n = 1'b0;
    logic        b_imem_en;
    logic [9:0]  b_imem_addr;
    logic [31:0] b_imem_rdata = 32'h0;
    logic        b_redirect_valid = 1'b0;
    logic [31:0] b_redirect_pc = 32'h0;
    logic        b_halt_req = 1'b0;
    logic        b_instr_valid;
    logic        b_instr_ready = 1'b1;
    logic [31:0] b_instr_out;
    logic [31:0] b_instr_pc;
    logic        b_halted;

    logic [31:0] mem [0:1023];

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk            (clk),
        .rst_n          (b_rst_n),
        .imem_en        (b_imem_en),
        .imem_addr      (b_imem_addr),
        .imem_rdata     (b_imem_rdata),
        .redirect_valid (b_redirect_valid),
        .redirect_pc    (b_redirect_pc),
        .halt_req       (b_halt_req),
        .instr_valid    (b_instr_valid),
        .instr_ready    (b_instr_ready),
        .instr_out      (b_instr_out),
        .instr_pc       (b_instr_pc),
        .halted         (b_halted)
    );

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem[imem_addr];
        if (b_imem_en) b_imem_rdata <= mem[b_imem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] d, input logic [31:0] p);
        $display("xfer %s: valid=%0d instr=%08h pc=%08h", tag, instr_valid, instr_out, instr_pc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".data"},  instr_out, d);
        check({tag, ".pc"},    instr_pc,  p);
    endtask

    // Hold reset for two edges with idle inputs, then release mid-cycle.
    task automatic do_reset();
        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = WA;
        mem[1] = WB;
        mem[2] = WC;
        mem[3] = WD;

        // ---- reset state and in-order streaming ----
        rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt_req = 1'b0;
        step(2);
        check("rst.imem_en", 32'(imem_en), 32'd0);
        check("rst.valid",   32'(instr_valid), 32'd0);
        check("rst.halted",  32'(halted), 32'd0);
        check("rst.instr",   instr_out, 32'h0);
        check("rst.pc",      instr_pc, 32'h0);
        rst_n = 1'b1;
        step();   // BOOT -> RUN, first read
        check("s1.en1",   32'(imem_en), 32'd1);
        check("s1.addr1", 32'(imem_addr), 32'h0);
        check("s1.v1",    32'(instr_valid), 32'd0);
        step();
        check("s1.v2",    32'(instr_valid), 32'd0);
        step(); check_out("s1.A", WA, 32'd0);
        step(); check_out("s1.B", WB, 32'd1);
        step(); check_out("s1.C", WC, 32'd2);
        step(); check_out("s1.D", WD, 32'd3);

        // ---- three-cycle stall while B is presented ----
        do_reset();
        step(4); check_out("s2.B0", WB, 32'd1);
        instr_ready = 1'b0;
        step(); check_out("s2.B1", WB, 32'd1);
        check("s2.en_stall", 32'(imem_en), 32'd0);
        step(); check_out("s2.B2", WB, 32'd1);
        step(); check_out("s2.B3", WB, 32'd1);
        instr_ready = 1'b1;
        step(); check_out("s2.C", WC, 32'd2);
        step(); check_out("s2.D", WD, 32'd3);
        step(); check_out("s2.W4", 32'h1000_0004, 32'd4);

        // ---- redirect to 0x40 while C is returning ----
        do_reset();
        step(4); check_out("s3.B", WB, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("s3.v1",    32'(instr_valid), 32'd0);
        check("s3.en",    32'(imem_en), 32'd1);
        check("s3.addr",  32'(imem_addr), 32'h40);
        step();
        check("s3.v2",    32'(instr_valid), 32'd0);
        step(); check_out("s3.T0", 32'h1000_0040, 32'h40);
        step(); check_out("s3.T1", 32'h1000_0041, 32'h41);

        // ---- redirect and halt together: redirect wins ----
        do_reset();
        step(4); check_out("s4.B", WB, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h8; halt_req = 1'b1;
        step();
        redirect_valid = 1'b0; halt_req = 1'b0;
        check("s4.v1",     32'(instr_valid), 32'd0);
        check("s4.halt1",  32'(halted), 32'd0);
        step(2); check_out("s4.T0", 32'h1000_0008, 32'h8);
        check("s4.halt2",  32'(halted), 32'd0);
        step(); check_out("s4.T1", 32'h1000_0009, 32'h9);
        check("s4.halt3",  32'(halted), 32'd0);

        // ---- halt pulse during a stall: drain, then ignore redirect ----
        do_reset();
        step(4); check_out("s5.B0", WB, 32'd1);
        instr_ready = 1'b0; halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("s5.halt0", 32'(halted), 32'd0);
        check_out("s5.B1", WB, 32'd1);
        step();
        check("s5.halt1", 32'(halted), 32'd1);
        check("s5.en1",   32'(imem_en), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        check_out("s5.B2", WB, 32'd1);
        check("s5.en2",   32'(imem_en), 32'd0);
        instr_ready = 1'b1;
        step(); check_out("s5.C", WC, 32'd2);
        step();
        check("s5.v_end", 32'(instr_valid), 32'd0);
        step();
        check("s5.v_end2", 32'(instr_valid), 32'd0);
        check("s5.halt2",  32'(halted), 32'd1);
        check("s5.en3",    32'(imem_en), 32'd0);

        // ---- wrap-around boot address with a mid-stream reset ----
        b_rst_n = 1'b1;
        step(6);
        check("s6.mid_valid", 32'(b_instr_valid), 32'd1);
        check("s6.mid_pc",    b_instr_pc, 32'd2);
        #2;
        b_rst_n = 1'b0;
        #1;
        check("s6.rst_valid", 32'(b_instr_valid), 32'd0);
        check("s6.rst_en",    32'(b_imem_en), 32'd0);
        check("s6.rst_pc",    b_instr_pc, 32'h0);
        check("s6.rst_instr", b_instr_out, 32'h0);
        step();
        b_rst_n = 1'b1;
        step();
        check("s6.en",   32'(b_imem_en), 32'd1);
        check("s6.addr", 32'(b_imem_addr), 32'h3FF);
        step();
        check("s6.v2",   32'(b_instr_valid), 32'd0);
        step();
        $display("xfer s6.T0: valid=%0d instr=%08h pc=%08h", b_instr_valid, b_instr_out, b_instr_pc);
        check("s6.T0.valid", 32'(b_instr_valid), 32'd1);
        check("s6.T0.pc",    b_instr_pc, 32'hFFFF_FFFF);
        check("s6.T0.data",  b_instr_out, 32'h1000_03FF);
        step();
        $display("xfer s6.T1: valid=%0d instr=%08h pc=%08h", b_instr_valid, b_instr_out, b_instr_pc);
        check("s6.T1.valid", 32'(b_instr_valid), 32'd1);
        check("s6.T1.pc",    b_instr_pc, 32'h0);
        check("s6.T1.data",  b_instr_out, WA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
